inst_rom_loader: RTL and testbench

Instruction-memory responder for the pipeline's fetch port, with a byte-serial program loader. The core drives `rom_ce_o`/`rom_addr_o` and samples `rom_data_i` in the same cycle. This block answers that fetch combinationally from an internal word array. A loader FSM fills the array from a byte stream and holds the core in reset (`cpu_hold_o`) until a complete program has been committed.

---
 rtl/inst_rom_loader.sv | 146 ++++++++++++++
 tb/tb_inst_rom_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_rom_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_rom_loader
// Purpose  : Combinational instruction ROM for the fetch port, filled by a
//            byte-serial loader that holds the core in reset until committed.
// Revision : 1.0
// ============================================================================
module inst_rom_loader #(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic [31:0] addr_i,
   output logic [31:0] inst_o,
   input  logic        load_start_i,
   input  logic        load_valid_i,
   input  logic [7:0]  load_byte_i,
   input  logic        load_last_i,
   output logic        load_ready_o,
   output logic        load_done_o,
   output logic        load_ovf_o,
   output logic        cpu_hold_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] S_WAIT  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_RUN   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W:0]   wptr_q, wptr_d;
   logic [1:0]        bcnt_q, bcnt_d;
   logic [31:0]       asm_q, asm_d;
   logic              ovf_q, ovf_d;

   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem [DEPTH];

   logic [31:0]       byte_word;
   logic              wptr_full;
   logic              in_range;
   logic              unused_addr_lsbs;

   // wptr is one bit wider than the array index so "full" is its MSB.
   assign wptr_full = wptr_q[ADDR_W];

   // Assembly register with the incoming byte dropped into its big-endian lane.
   always_comb begin
      byte_word = asm_q;
      case (bcnt_q)
         2'd0: byte_word[31:24] = load_byte_i;
         2'd1: byte_word[23:16] = load_byte_i;
         2'd2: byte_word[15:8]  = load_byte_i;
         2'd3: byte_word[7:0]   = load_byte_i;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      wptr_d    = wptr_q;
      bcnt_d    = bcnt_q;
      asm_d     = asm_q;
      ovf_d     = ovf_q;
      mem_we    = 1'b0;
      mem_waddr = wptr_q[ADDR_W-1:0];
      mem_wdata = byte_word;
      case (state_q)
         S_WAIT, S_RUN: begin
            if (load_start_i) begin
               state_d = S_LOAD;
               wptr_d  = '0;
               bcnt_d  = 2'd0;
               asm_d   = 32'h0;
               ovf_d   = 1'b0;
            end
         end
         S_LOAD: begin
            if (load_start_i) begin
               wptr_d = '0;
               bcnt_d = 2'd0;
               asm_d  = 32'h0;
               ovf_d  = 1'b0;
            end else if (load_valid_i) begin
               if (bcnt_q == 2'd3 || load_last_i) begin
                  asm_d  = 32'h0;
                  bcnt_d = 2'd0;
                  // Past the end of the array the stream keeps flowing but is dropped.
                  if (wptr_full) begin
                     ovf_d = 1'b1;
                  end else begin
                     mem_we = 1'b1;
                     wptr_d = wptr_q + {{ADDR_W{1'b0}}, 1'b1};
                  end
               end else begin
                  asm_d  = byte_word;
                  bcnt_d = bcnt_q + 2'd1;
               end
               if (load_last_i) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: state_d = S_RUN;
         default: state_d = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_WAIT;
         wptr_q  <= '0;
         bcnt_q  <= 2'd0;
         asm_q   <= 32'h0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         bcnt_q  <= bcnt_d;
         asm_q   <= asm_d;
         ovf_q   <= ovf_d;
      end
   end

   // Program storage survives reset so an aborted reload keeps committed words.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   assign in_range         = (addr_i[31:ADDR_W+2] == '0);
   assign inst_o           = (ce_i && in_range) ? mem[addr_i[ADDR_W+1:2]] : 32'h0;
   assign unused_addr_lsbs = ^addr_i[1:0];

   assign load_ready_o = (state_q == S_LOAD);
   assign load_done_o  = (state_q == S_FLUSH);
   assign cpu_hold_o   = (state_q != S_RUN);
   assign load_ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_inst_rom_loader
// Purpose  : Self-checking bench for inst_rom_loader at ADDR_W=10 and ADDR_W=2.
// Revision : 1.0
// ============================================================================
module tb_inst_rom_loader;
   typedef logic [7:0] bytes_t[$];

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce_i = 1'b0;
   logic [31:0] addr_i = 32'h0;
   logic        load_start_i = 1'b0;
   logic        load_valid_i = 1'b0;
   logic [7:0]  load_byte_i = 8'h0;
   logic        load_last_i = 1'b0;

   logic [31:0] inst_a, inst_b;
   logic        rdy_a, rdy_b, done_a, done_b, ovf_a, ovf_b, hold_a, hold_b;

   int total = 0;
   int bad   = 0;

   // Reference contents: what each array should hold, and which words are defined.
   logic [31:0] m10 [1024];
   bit          k10 [1024];
   logic [31:0] m2  [4];
   bit          k2  [4];
   logic        ovf2_m = 1'b0;

   always #5 clk = ~clk;

   inst_rom_loader #(.ADDR_W(10)) dut_a (
      .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst_a),
      .load_start_i(load_start_i), .load_valid_i(load_valid_i),
      .load_byte_i(load_byte_i), .load_last_i(load_last_i),
      .load_ready_o(rdy_a), .load_done_o(done_a), .load_ovf_o(ovf_a),
      .cpu_hold_o(hold_a)
   );

   inst_rom_loader #(.ADDR_W(2)) dut_b (
      .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst_b),
      .load_start_i(load_start_i), .load_valid_i(load_valid_i),
      .load_byte_i(load_byte_i), .load_last_i(load_last_i),
      .load_ready_o(rdy_b), .load_done_o(done_b), .load_ovf_o(ovf_b),
      .cpu_hold_o(hold_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A finished program becomes big-endian words; words past the array end set overflow.
   task automatic model_commit(input bytes_t q);
      int nw;
      logic [31:0] w;
      nw = (q.size() + 3) / 4;
      ovf2_m = 1'b0;
      for (int i = 0; i < nw; i++) begin
         w = 32'h0;
         for (int k = 0; k < 4; k++) begin
            if (4 * i + k < q.size()) w[31 - 8 * k -: 8] = q[4 * i + k];
         end
         if (i < 1024) begin m10[i] = w; k10[i] = 1'b1; end
         if (i < 4) begin m2[i] = w; k2[i] = 1'b1; end
         else ovf2_m = 1'b1;
      end
   endtask

   task automatic check_fetch(input logic ce, input logic [31:0] a);
      logic [31:0] ea, eb;
      bit ca, cb;
      ce_i   = ce;
      addr_i = a;
      #1;
      ca = 1'b1;
      cb = 1'b1;
      if (!ce || a[31:12] != 20'h0) ea = 32'h0;
      else if (k10[a[11:2]]) ea = m10[a[11:2]];
      else begin ea = 32'h0; ca = 1'b0; end
      if (!ce || a[31:4] != 28'h0) eb = 32'h0;
      else if (k2[a[3:2]]) eb = m2[a[3:2]];
      else begin eb = 32'h0; cb = 1'b0; end
      if (ca) check("fetch_a", inst_a, ea);
      if (cb) check("fetch_b", inst_b, eb);
      ce_i = 1'b0;
   endtask

   task automatic start_load();
      load_start_i = 1'b1;
      tick();
      load_start_i = 1'b0;
      check("start_hold_a", hold_a, 1);
      check("start_rdy_a", rdy_a, 1);
      check("start_rdy_b", rdy_b, 1);
      check("start_ovf_b", ovf_b, 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      load_valid_i = 1'b1;
      load_byte_i  = b;
      load_last_i  = last;
      tick();
      load_valid_i = 1'b0;
      load_last_i  = 1'b0;
   endtask

   task automatic stream_program(input bytes_t q);
      for (int i = 0; i < q.size(); i++) begin
         check("ready_a", rdy_a, 1);
         check("ready_b", rdy_b, 1);
         send_byte(q[i], i == q.size() - 1);
      end
      check("flush_done_a", done_a, 1);
      check("flush_done_b", done_b, 1);
      check("flush_hold_a", hold_a, 1);
      check("flush_rdy_a", rdy_a, 0);
      tick();
      check("run_done_a", done_a, 0);
      check("run_hold_a", hold_a, 0);
      check("run_hold_b", hold_b, 0);
      model_commit(q);
      check("ovf_a", ovf_a, 0);
      check("ovf_b", ovf_b, ovf2_m);
   endtask

   initial begin
      bytes_t q;
      for (int i = 0; i < 1024; i++) k10[i] = 1'b0;
      for (int i = 0; i < 4; i++) k2[i] = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_hold", hold_a, 1);
      check("rst_rdy", rdy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_ovf", ovf_b, 0);
      check_fetch(1'b0, 32'h0);
      rst = 1'b0;
      tick();
      check("wait_hold", hold_a, 1);
      check("wait_rdy", rdy_a, 0);

      // Two-word program.
      q = '{8'h34, 8'h02, 8'h00, 8'h01, 8'h24, 8'h03, 8'h00, 8'h02};
      start_load();
      stream_program(q);
      check_fetch(1'b1, 32'h4);
      check("t1_word1", inst_a, 32'h24030002);
      check_fetch(1'b1, 32'h0);
      check_fetch(1'b0, 32'h4);
      check_fetch(1'b1, 32'h0000_1000);

      // Partial final word: unfilled lanes zero, second word untouched.
      q = '{8'hAA, 8'hBB, 8'hCC};
      start_load();
      stream_program(q);
      ce_i = 1'b1; addr_i = 32'h0; #1;
      check("t2_word0", inst_a, 32'hAABBCC00);
      ce_i = 1'b0;
      check_fetch(1'b1, 32'h4);

      // Reload from RUN, then restart mid-word with a byte that must be dropped.
      load_start_i = 1'b1;
      tick();
      load_start_i = 1'b0;
      check("reload_hold", hold_a, 1);
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      load_start_i = 1'b1;
      load_valid_i = 1'b1;
      load_byte_i  = 8'h33;
      tick();
      load_start_i = 1'b0;
      load_valid_i = 1'b0;
      q = '{8'h55, 8'h66, 8'h77, 8'h88};
      stream_program(q);
      ce_i = 1'b1; addr_i = 32'h0; #1;
      check("t3_word0", inst_a, 32'h55667788);
      ce_i = 1'b0;
      check_fetch(1'b1, 32'h4);

      // Overflow on the 4-word instance.
      q = {};
      for (int i = 0; i < 21; i++) q.push_back(8'(i + 1));
      start_load();
      stream_program(q);
      repeat (2) tick();
      check("ovf_sticky_b", ovf_b, 1);
      check("ovf_run_hold_b", hold_b, 0);
      ce_i = 1'b1; addr_i = 32'h0; #1;
      check("ovf_word0_b", inst_b, 32'h01020304);
      ce_i = 1'b0;
      for (int i = 0; i < 6; i++) check_fetch(1'b1, 32'(4 * i));

      // Asynchronous reset mid-load.
      start_load();
      send_byte(8'hDE, 1'b0);
      send_byte(8'hAD, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      check("arst_hold", hold_a, 1);
      check("arst_rdy", rdy_a, 0);
      check("arst_ovf_b", ovf_b, 0);
      tick();
      rst = 1'b0;
      tick();
      check("arst_wait_hold", hold_b, 1);
      for (int i = 0; i < 6; i++) check_fetch(1'b1, 32'(4 * i));

      // Random programs and fetches.
      for (int r = 0; r < 8; r++) begin
         q = {};
         for (int i = 0; i < int'($urandom_range(20, 1)); i++)
            q.push_back(8'($urandom_range(255, 0)));
         start_load();
         stream_program(q);
         for (int f = 0; f < 4; f++)
            check_fetch(1'b1, {20'h0, 10'($urandom_range(7, 0)), 2'($urandom_range(3, 0))});
         check_fetch(1'b1, $urandom | 32'h0000_1000);
         check_fetch(1'b0, 32'(4 * $urandom_range(3, 0)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
